tlul_byte_host: RTL and testbench

//  Byte-stream-to-TL-UL host bridge driving the crossbar's external host port (tl_ext_h2d/d2h).

---
 rtl/tlul_byte_host_if.sv | 71 +++++++
 rtl/tlul_byte_host.sv | 189 ++++++++++++++++++
 tb/tb_tlul_byte_host.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_byte_host_if.sv
// TL-UL type package and byte-host bus interface for tlul_byte_host.
// The package carries the subset of TL-UL channel types the bridge drives;
// the interface bundles the byte source/sink handshakes with the TL channels.
package tlul_byte_host_pkg;
  parameter int TL_AIW = 8;
  parameter int TL_DIW = 1;
  parameter int TL_AW  = 32;
  parameter int TL_DW  = 32;
  parameter int TL_DBW = 4;
  parameter int TL_SZW = 2;
  parameter int TL_AUW = 16;
  parameter int TL_DUW = 16;

  parameter logic [2:0] PutFullData   = 3'h0;
  parameter logic [2:0] Get           = 3'h4;
  parameter logic [2:0] AccessAck     = 3'h0;
  parameter logic [2:0] AccessAckData = 3'h1;

  parameter logic [TL_AUW-1:0] TL_A_USER_DEFAULT = '0;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [TL_AUW-1:0] a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [TL_DUW-1:0] d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

interface tlul_byte_host_if;
  import tlul_byte_host_pkg::*;

  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  tl_h2d_t    tl_o;
  tl_d2h_t    tl_i;

  // bridge side
  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i, tl_i,
    output rx_ready_o, tx_data_o, tx_valid_o, tl_o
  );

  // byte source/sink and TL device side
  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i, tl_i,
    input  rx_ready_o, tx_data_o, tx_valid_o, tl_o
  );
endinterface

// File: rtl/tlul_byte_host.sv
// Byte-stream to TL-UL host bridge. Parses 'R'/'W' command frames (addr and
// data LSB first), issues one single-beat 32-bit Get/PutFullData at a time,
// and streams back a status byte plus read data.
// Optional inter-byte abort: define TLUL_BYTE_HOST_RX_TIMEOUT_EN.
module tlul_byte_host
  import tlul_byte_host_pkg::*;
#(
  parameter logic [TL_AIW-1:0] SourceId        = '0,
  parameter int unsigned       RxTimeoutCycles = 100000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  tlul_byte_host_if.master   bus,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    IDLE, RX_ADDR, RX_DATA, REQ, RSP, TX_STATUS, TX_DATA
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        is_wr_q, is_wr_d;
  logic        bad_q, bad_d;
  logic [7:0]  status_q, status_d;

  logic        rx_hs, tx_hs, timeout;
  tl_h2d_t     tl_o_s;

  assign bus.rx_ready_o = (state_q == IDLE) || (state_q == RX_ADDR) || (state_q == RX_DATA);
  assign rx_hs          = bus.rx_valid_i & bus.rx_ready_o;
  assign tx_hs          = bus.tx_valid_o & bus.tx_ready_i;
  assign busy_o         = (state_q != IDLE);
  assign bus.tl_o       = tl_o_s;

  logic unused_tl;
  assign unused_tl = ^{bus.tl_i.d_opcode, bus.tl_i.d_param, bus.tl_i.d_size,
                       bus.tl_i.d_source, bus.tl_i.d_sink, bus.tl_i.d_user};

`ifdef TLUL_BYTE_HOST_RX_TIMEOUT_EN
  localparam int TW = $clog2(RxTimeoutCycles + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(RxTimeoutCycles);

  logic [TW-1:0] to_q, to_d;

  // idle-gap counter: runs only while a frame is partially received
  always_comb begin
    to_d    = '0;
    timeout = 1'b0;
    if (!rx_hs && (state_q == RX_ADDR || state_q == RX_DATA)) begin
      if (to_q == TO_LIMIT) timeout = 1'b1;
      else                  to_d    = to_q + 1'b1;
    end
  end

  // timeout counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) to_q <= '0;
    else         to_q <= to_d;
  end
`else
  localparam int unsigned unused_rx_timeout = RxTimeoutCycles;
  assign timeout = 1'b0;
`endif

  // frame parser, TL request/response and tx sequencing
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    addr_d           = addr_q;
    data_d           = data_q;
    is_wr_d          = is_wr_q;
    bad_d            = bad_q;
    status_d         = status_q;
    bus.tx_valid_o   = 1'b0;
    bus.tx_data_o    = status_q;

    // A fields come straight from registers so they hold while a_ready is low
    tl_o_s           = '0;
    tl_o_s.a_opcode  = is_wr_q ? PutFullData : Get;
    tl_o_s.a_param   = 3'h0;
    tl_o_s.a_size    = 2'd2;
    tl_o_s.a_source  = SourceId;
    tl_o_s.a_address = {addr_q[31:2], 2'b00};
    tl_o_s.a_mask    = 4'hF;
    tl_o_s.a_data    = data_q;
    tl_o_s.a_user    = TL_A_USER_DEFAULT;

    unique case (state_q)
      IDLE: begin
        if (rx_hs) begin
          if (bus.rx_data_i == 8'h52 || bus.rx_data_i == 8'h57) begin
            is_wr_d = (bus.rx_data_i == 8'h57);
            bad_d   = 1'b0;
            cnt_d   = 2'd0;
            state_d = RX_ADDR;
          end else begin
            bad_d    = 1'b1;
            status_d = 8'hEE;
            state_d  = TX_STATUS;
          end
        end
      end
      RX_ADDR: begin
        if (rx_hs) begin
          addr_d[{cnt_q, 3'b000} +: 8] = bus.rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = is_wr_q ? RX_DATA : REQ;
        end
      end
      RX_DATA: begin
        if (rx_hs) begin
          data_d[{cnt_q, 3'b000} +: 8] = bus.rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = REQ;
        end
      end
      REQ: begin
        tl_o_s.a_valid = 1'b1;
        tl_o_s.d_ready = 1'b1;
        if (bus.tl_i.a_ready) begin
          // zero-latency device may answer in the A handshake cycle
          if (bus.tl_i.d_valid) begin
            data_d   = bus.tl_i.d_data;
            status_d = bus.tl_i.d_error ? 8'h01 : 8'h00;
            state_d  = TX_STATUS;
          end else begin
            state_d  = RSP;
          end
        end
      end
      RSP: begin
        tl_o_s.d_ready = 1'b1;
        if (bus.tl_i.d_valid) begin
          data_d   = bus.tl_i.d_data;
          status_d = bus.tl_i.d_error ? 8'h01 : 8'h00;
          state_d  = TX_STATUS;
        end
      end
      TX_STATUS: begin
        bus.tx_valid_o = 1'b1;
        bus.tx_data_o  = status_q;
        if (tx_hs) begin
          cnt_d   = 2'd0;
          state_d = (bad_q || is_wr_q) ? IDLE : TX_DATA;
        end
      end
      TX_DATA: begin
        bus.tx_valid_o = 1'b1;
        bus.tx_data_o  = data_q[{cnt_q, 3'b000} +: 8];
        if (tx_hs) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // a stalled partial frame is dropped without any response
    if (timeout) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      addr_q   <= '0;
      data_q   <= '0;
      is_wr_q  <= 1'b0;
      bad_q    <= 1'b0;
      status_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      is_wr_q  <= is_wr_d;
      bad_q    <= bad_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_tlul_byte_host.sv
// Bench for tlul_byte_host: byte driver, TL device model with configurable
// stalls/latency/error, and a tx sink; expected TL requests and tx bytes are
// queued when a frame is driven and compared when the DUT produces them.
module tb_tlul_byte_host;
  import tlul_byte_host_pkg::*;

  localparam logic [TL_AIW-1:0] SRC = 8'h5A;
  localparam int TO = 40;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic busy_o;

  tlul_byte_host_if bus();

  tlul_byte_host #(.SourceId(SRC), .RxTimeoutCycles(TO)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } areq_t;

  areq_t      exp_a[$];
  logic [7:0] exp_tx[$];
  int a_cnt = 0, tx_cnt = 0;

  int          dev_wait = 1, a_stall = 0, dev_st = 0;
  logic        dev_err = 1'b0;
  logic [31:0] dev_data = '0;
  int          tx_stall = 0, tx_stall_at = -1;

  // TL device model
  initial begin
    int      stall, wcnt;
    logic    seen;
    tl_h2d_t snap;
    areq_t   e;
    stall = 0; wcnt = 0; seen = 1'b0;
    bus.tl_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        bus.tl_i = '0; dev_st = 0; stall = 0; seen = 1'b0;
        continue;
      end
      case (dev_st)
        0: begin
          bus.tl_i.a_ready = 1'b0;
          if (bus.tl_o.a_valid) begin
            chk("rx_rdy_req", bus.rx_ready_o, 0);
            chk("d_rdy_req", bus.tl_o.d_ready, 1);
            if (seen) begin
              chk("a_addr_stable", bus.tl_o.a_address, snap.a_address);
              chk("a_data_stable", bus.tl_o.a_data, snap.a_data);
              chk("a_op_stable", bus.tl_o.a_opcode, snap.a_opcode);
            end else begin
              snap = bus.tl_o; seen = 1'b1;
            end
            if (stall < a_stall) stall++;
            else begin
              bus.tl_i.a_ready = 1'b1;
              stall = 0; seen = 1'b0; a_cnt++;
              if (exp_a.size() == 0) chk("a_unexpected", 1, 0);
              else begin
                e = exp_a.pop_front();
                chk("a_opcode", bus.tl_o.a_opcode, e.op);
                chk("a_addr", bus.tl_o.a_address, e.addr);
                if (e.op == PutFullData) chk("a_data", bus.tl_o.a_data, e.data);
                chk("a_mask", bus.tl_o.a_mask, 4'hF);
                chk("a_size", bus.tl_o.a_size, 2);
                chk("a_source", bus.tl_o.a_source, SRC);
                chk("a_param", bus.tl_o.a_param, 0);
              end
              bus.tl_i.d_data   = dev_data;
              bus.tl_i.d_error  = dev_err;
              bus.tl_i.d_opcode = (bus.tl_o.a_opcode == Get) ? AccessAckData : AccessAck;
              if (dev_wait == 0) begin
                bus.tl_i.d_valid = 1'b1; dev_st = 2;
              end else begin
                wcnt = dev_wait; dev_st = 1;
              end
            end
          end
        end
        1: begin
          bus.tl_i.a_ready = 1'b0;
          chk("d_rdy_rsp", bus.tl_o.d_ready, 1);
          chk("rx_rdy_rsp", bus.rx_ready_o, 0);
          chk("a_vld_rsp", bus.tl_o.a_valid, 0);
          wcnt--;
          if (wcnt == 0) begin
            bus.tl_i.d_valid = 1'b1; dev_st = 2;
          end
        end
        default: begin
          bus.tl_i.a_ready = 1'b0;
          bus.tl_i.d_valid = 1'b0;
          chk("tx_lat", bus.tx_valid_o, 1);
          dev_st = 0;
        end
      endcase
    end
  end

  // tx sink with optional stall on one byte index
  initial begin
    int         held;
    logic [7:0] snap, e;
    held = 0;
    bus.tx_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      bus.tx_ready_i = 1'b0;
      if (!rst_ni) begin
        held = 0;
        continue;
      end
      if (bus.tx_valid_o) begin
        chk("rx_rdy_tx", bus.rx_ready_o, 0);
        if (held > 0) chk("tx_stable", bus.tx_data_o, snap);
        else snap = bus.tx_data_o;
        if (tx_cnt == tx_stall_at && held < tx_stall) held++;
        else begin
          bus.tx_ready_i = 1'b1;
          held = 0;
          tx_cnt++;
          if (exp_tx.size() == 0) chk("tx_unexpected", bus.tx_data_o, 0);
          else begin
            e = exp_tx.pop_front();
            chk("tx_byte", bus.tx_data_o, e);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk_i);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    while (!bus.rx_ready_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 2000) chk("rx_accept_timeout", 0, 1);
    @(posedge clk_i);
    #1 bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    areq_t r;
    logic  ok;
    ok = (op == 8'h52) || (op == 8'h57);
    if (ok) begin
      r.op   = (op == 8'h57) ? PutFullData : Get;
      r.addr = {addr[31:2], 2'b00};
      r.data = data;
      exp_a.push_back(r);
      exp_tx.push_back(dev_err ? 8'h01 : 8'h00);
      if (op == 8'h52) for (int i = 0; i < 4; i++) exp_tx.push_back(dev_data[8*i +: 8]);
    end else begin
      exp_tx.push_back(8'hEE);
    end
    send_byte(op);
    if (ok) begin
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
      if (op == 8'h57) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
    end
    @(negedge clk_i);
    if (ok) chk("a_lat", bus.tl_o.a_valid, 1);
    else    chk("bad_tx_lat", bus.tx_valid_o, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || busy_o) && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_done"}, (n < 5000), 1);
    chk({tag, "_a_left"}, exp_a.size(), 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_rx_rdy"}, bus.rx_ready_o, 1);
  endtask

  initial begin
    int n_a, n_t, n;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_tx_vld", bus.tx_valid_o, 0);
    chk("rst_a_vld", bus.tl_o.a_valid, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_rx_rdy", bus.rx_ready_o, 1);

    // write, D one cycle after A
    dev_wait = 1; dev_err = 1'b0; dev_data = 32'h0;
    send_frame(8'h57, 32'h8000_0000, 32'hDEAD_BEEF);
    wait_done("t1");

    // read with 3 wait cycles
    dev_wait = 3; dev_data = 32'h1234_5678;
    send_frame(8'h52, 32'h8000_0004, 32'h0);
    wait_done("t2");

    // read error
    dev_err = 1'b1; dev_data = 32'hCAFE_F00D;
    send_frame(8'h52, 32'h4000_0000, 32'h0);
    wait_done("t3");

    // bad opcode, then normal read
    dev_err = 1'b0; n_a = a_cnt;
    send_frame(8'h41, 32'h0, 32'h0);
    wait_done("t4a");
    chk("t4_no_a", a_cnt, n_a);
    dev_data = 32'hA5A5_5A5A;
    send_frame(8'h52, 32'h8000_0010, 32'h0);
    wait_done("t4b");

    // A stall, tx stall on second data byte, unaligned address
    a_stall = 5; tx_stall = 3; tx_stall_at = tx_cnt + 2;
    dev_data = 32'h0BAD_F00D;
    send_frame(8'h52, 32'h8000_0007, 32'h0);
    wait_done("t5");
    a_stall = 0; tx_stall_at = -1;

    // zero-latency device, back-to-back frames
    dev_wait = 0; dev_data = 32'h7766_5544;
    send_frame(8'h57, 32'h0000_0010, 32'h0102_0304);
    send_frame(8'h52, 32'h0000_0014, 32'h0);
    wait_done("t_zl");

    // reset during RSP
    dev_wait = 20;
    send_frame(8'h52, 32'h8000_0020, 32'h0);
    n = 0;
    while (dev_st != 1 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("t6_reach_rsp", dev_st, 1);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("t6_busy", busy_o, 0);
    chk("t6_tx_vld", bus.tx_valid_o, 0);
    chk("t6_a_vld", bus.tl_o.a_valid, 0);
    exp_tx.delete();
    exp_a.delete();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("t6_rx_rdy", bus.rx_ready_o, 1);
    dev_wait = 1; dev_data = 32'h3141_5926;
    send_frame(8'h52, 32'h8000_0024, 32'h0);
    wait_done("t6b");

`ifdef TLUL_BYTE_HOST_RX_TIMEOUT_EN
    // partial frame times out silently
    n_a = a_cnt; n_t = tx_cnt;
    send_byte(8'h57);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TO / 2) @(negedge clk_i);
    chk("to_busy_mid", busy_o, 1);
    repeat (TO) @(negedge clk_i);
    chk("to_busy_end", busy_o, 0);
    chk("to_no_a", a_cnt, n_a);
    chk("to_no_tx", tx_cnt, n_t);
    dev_data = 32'h2718_2818;
    send_frame(8'h52, 32'h8000_0030, 32'h0);
    wait_done("to_next");
`else
    n_a = a_cnt; n_t = tx_cnt;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
